moonbase_bus_arbiter: RTL

- Shares the single multiplexed external bus (7-bit address latch + nibble SRAM + 2-bit device port) between two requesters, r0 and r1. Typically r0 is the 4-bit CPU core and r1 a loader/DMA engine.
- Sequences each transaction as an address-strobe phase followed by a data/write phase.
- Drives the same 8-bit bus_out encoding the CPU core uses, so the external latch/SRAM wiring is unchanged.

---
 rtl/moonbase_bus_pkg.sv | 37 +++
 rtl/moonbase_rr_pick.sv | 25 ++
 rtl/moonbase_bus_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/moonbase_bus_pkg.sv
// Shared types and bus encoding for the moonbase external bus arbiter.
// The 8-bit bus word matches the CPU core's latch/SRAM wiring.
package moonbase_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [7:0] BUS_IDLE = 8'h70;

  localparam int STROBE    = 7;
  localparam int SPACE     = 6;
  localparam int WR_RAM_N  = 5;
  localparam int WR_DATA_N = 4;

  typedef struct packed {
    logic       we;
    logic       dev;
    logic       space;
    logic [6:0] addr;
    logic [3:0] wdata;
  } xact_t;

  // Data-phase bus word; both write strobes stay high on reads.
  function automatic logic [7:0] xfer_bus(input xact_t x);
    logic [7:0] b;
    b            = '0;
    b[SPACE]     = x.space;
    b[WR_RAM_N]  = x.we ? x.dev : 1'b1;
    b[WR_DATA_N] = x.we ? ~x.dev : 1'b1;
    b[3:0]       = x.wdata;
    return b;
  endfunction

endpackage

// File: rtl/moonbase_rr_pick.sv
// Two-way requester pick: round-robin against last winner or fixed r0 priority.
// The requester being acked this cycle is masked out so it cannot win twice.
module moonbase_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  input  logic [1:0] exclude,
  output logic       win_valid,
  output logic       win_idx
);

  logic [1:0] cand;

  always_comb begin
    cand      = req & ~exclude;
    win_valid = |cand;
    win_idx   = 1'b0;
    if (cand == 2'b11) begin
      win_idx = rr ? ~last : 1'b0;
    end else begin
      win_idx = cand[1];
    end
  end

endmodule

// File: rtl/moonbase_bus_arbiter.sv
// Arbitrates the multiplexed external bus between r0 and r1, sequencing each
// transaction as an address strobe followed by a read or timed write phase.
module moonbase_bus_arbiter
  import moonbase_bus_pkg::*;
#(
  parameter bit RR        = 1'b1,
  parameter int WR_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r0_req,
  input  logic       r0_we,
  input  logic       r0_dev,
  input  logic       r0_space,
  input  logic [6:0] r0_addr,
  input  logic [3:0] r0_wdata,
  output logic       r0_ack,
  output logic [3:0] r0_rdata,
  input  logic       r1_req,
  input  logic       r1_we,
  input  logic       r1_dev,
  input  logic       r1_space,
  input  logic [6:0] r1_addr,
  input  logic [3:0] r1_wdata,
  output logic       r1_ack,
  output logic [3:0] r1_rdata,
  input  logic [3:0] ram_in,
  input  logic [1:0] dev_in,
  output logic [7:0] bus_out,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [1:0] WR_LOAD = 2'(WR_CYCLES - 1);

  state_t     state_q, state_d;
  xact_t      xact_q, r0_x, r1_x, win_x;
  logic       owner_q, last_q;
  logic [1:0] wcnt_q;
  logic       xfer_last, arb_en, win_valid, win_idx;
  logic [1:0] ack_vec;
  logic [3:0] rd_data;

  assign r0_x = {r0_we, r0_dev, r0_space, r0_addr, r0_wdata};
  assign r1_x = {r1_we, r1_dev, r1_space, r1_addr, r1_wdata};

  assign xfer_last = (state_q == XFER) && (!xact_q.we || (wcnt_q == 2'd0));
  assign ack_vec   = xfer_last ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign arb_en    = (state_q == IDLE) || xfer_last;

  moonbase_rr_pick u_pick (
    .req      ({r1_req, r0_req}),
    .last     (last_q),
    .rr       (RR),
    .exclude  (ack_vec),
    .win_valid(win_valid),
    .win_idx  (win_idx)
  );

  assign win_x = win_idx ? r1_x : r0_x;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_valid) state_d = ADDR;
      ADDR:    state_d = XFER;
      XFER:    if (xfer_last) state_d = win_valid ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fields are captured only at a win, so requesters may change them after ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      xact_q  <= '0;
      wcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if (arb_en && win_valid) begin
        xact_q  <= win_x;
        owner_q <= win_idx;
        last_q  <= win_idx;
      end
      if (state_q == ADDR) begin
        wcnt_q <= WR_LOAD;
      end else if ((state_q == XFER) && (wcnt_q != 2'd0)) begin
        wcnt_q <= wcnt_q - 2'd1;
      end
    end
  end

  always_comb begin
    bus_out = BUS_IDLE;
    unique case (state_q)
      ADDR: begin
        bus_out         = {1'b0, xact_q.addr};
        bus_out[STROBE] = 1'b1;
      end
      XFER:    bus_out = xfer_bus(xact_q);
      default: bus_out = BUS_IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign grant = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  // Read data passes straight through from the external parts during the ack cycle.
  assign rd_data  = xact_q.dev ? {2'b00, dev_in} : ram_in;
  assign r0_ack   = ack_vec[0];
  assign r1_ack   = ack_vec[1];
  assign r0_rdata = (ack_vec[0] && !xact_q.we) ? rd_data : 4'h0;
  assign r1_rdata = (ack_vec[1] && !xact_q.we) ? rd_data : 4'h0;

endmodule
